// File: rtl/mnist_image_reader_if.sv
// Image-memory read port plus the pixel stream toward the network input layer.
// The master side is the reader; the slave side is memory plus pixel consumer.
interface mnist_image_reader_if #(
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32
);
  logic [ADDR_WIDTH-1:0] rd_addr;
  logic                  rd_en;
  logic [DATA_WIDTH-1:0] rd_data;
  logic                  px_valid;
  logic                  px_ready;
  logic [DATA_WIDTH-1:0] px_data;
  logic [9:0]            px_index;
  logic                  px_last;

  modport master (
    output rd_addr, rd_en, px_valid, px_data, px_index, px_last,
    input  rd_data, px_ready
  );

  modport slave (
    input  rd_addr, rd_en, px_valid, px_data, px_index, px_last,
    output rd_data, px_ready
  );
endinterface

// File: rtl/mnist_image_reader.sv
// Scans the 28x28 image memory row-major and streams each pixel word over a
// valid/ready handshake through a 2-entry buffer, counting nonzero pixels.
module mnist_image_reader #(
  parameter int GRID_SIZE  = 28,
  parameter int NUM_PIXELS = GRID_SIZE * GRID_SIZE,
  parameter int ADDR_WIDTH = 16,
  parameter int DATA_WIDTH = 32,
  parameter int BASE_ADDR  = 0
) (
  input  logic                      clk,
  input  logic                      resetn,
  input  logic                      start,
  mnist_image_reader_if.master      bus,
  output logic                      busy,
  output logic                      done,
  output logic [9:0]                set_count
);
  typedef enum logic [1:0] {IDLE, SCAN, DRAIN} state_t;

  typedef struct packed {
    logic [DATA_WIDTH-1:0] data;
    logic [9:0]            index;
  } entry_t;

  localparam logic [9:0] LAST_IDX = 10'(NUM_PIXELS - 1);

  state_t     state, state_nxt;
  logic [9:0] idx;
  logic       issue, pop, accept_start;
  logic       inflight;
  logic [9:0] inflight_idx;
  entry_t     fifo_q [2];
  entry_t     head;
  logic       rd_ptr, wr_ptr;
  logic [1:0] cnt;

  assign head          = fifo_q[rd_ptr];
  assign bus.px_valid  = (cnt != 2'd0);
  assign bus.px_data   = head.data;
  assign bus.px_index  = head.index;
  assign bus.px_last   = bus.px_valid && (head.index == LAST_IDX);
  assign bus.rd_en     = issue;
  assign bus.rd_addr   = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(idx);
  assign busy          = (state != IDLE);
  assign pop           = bus.px_valid && bus.px_ready;

  always_comb begin
    state_nxt    = state;
    accept_start = 1'b0;
    issue        = 1'b0;
    case (state)
      // done high means DRAIN was left last cycle; a start here is ignored
      IDLE: if (start && !done) begin
        state_nxt    = SCAN;
        accept_start = 1'b1;
      end
      SCAN: begin
        // buffered + in-flight after this cycle's pop must leave room for one more
        issue = ({1'b0, cnt} + {2'b0, inflight}) < (3'd2 + {2'b0, pop});
        if (issue && idx == LAST_IDX) state_nxt = DRAIN;
      end
      DRAIN: if (pop && bus.px_last) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state        <= IDLE;
      idx          <= '0;
      inflight     <= 1'b0;
      inflight_idx <= '0;
      rd_ptr       <= 1'b0;
      wr_ptr       <= 1'b0;
      cnt          <= '0;
      fifo_q[0]    <= '0;
      fifo_q[1]    <= '0;
      done         <= 1'b0;
      set_count    <= '0;
    end else begin
      state    <= state_nxt;
      done     <= (state == DRAIN) && pop && bus.px_last;
      inflight <= issue;
      if (issue) inflight_idx <= idx;

      if (accept_start || (issue && idx == LAST_IDX)) idx <= '0;
      else if (issue)                                  idx <= idx + 10'd1;

      // read data lands one cycle after issue, tagged with its index
      if (inflight) begin
        fifo_q[wr_ptr] <= '{data: bus.rd_data, index: inflight_idx};
        wr_ptr         <= ~wr_ptr;
      end
      if (pop) rd_ptr <= ~rd_ptr;
      cnt <= cnt + {1'b0, inflight} - {1'b0, pop};

      if (accept_start)                       set_count <= '0;
      else if (pop && bus.px_data != '0)      set_count <= set_count + 10'd1;
    end
  end
endmodule

// File: tb/tb_mnist_image_reader.sv
// Randomized frame scans checked against an index-ordered scoreboard of memory contents.
module tb_mnist_image_reader;
  localparam int GS = 28, NP = 784, AW = 16, DW = 32;

  logic clk = 1'b0, resetn = 1'b0, start = 1'b0;
  logic busy, done;
  logic [9:0] set_count;

  mnist_image_reader_if #(.ADDR_WIDTH(AW), .DATA_WIDTH(DW)) bus ();

  mnist_image_reader #(
    .GRID_SIZE(GS), .ADDR_WIDTH(AW), .DATA_WIDTH(DW), .BASE_ADDR(0)
  ) dut (
    .clk(clk), .resetn(resetn), .start(start), .bus(bus.master),
    .busy(busy), .done(done), .set_count(set_count)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] mem [NP];
  always @(posedge clk) if (bus.rd_en) bus.rd_data <= mem[bus.rd_addr[9:0]];

  int n_cmp = 0, n_err = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, obs, exp, cyc);
    end
  endtask

  // scenario controls, written only by the stimulus process
  bit mon_en = 0;
  int frame_id = 0, exp_nz = 0, start_cyc = 0, rel_cyc = 0, lat_mode = 0;
  // scoreboard state, written only by the monitor
  int seen_id = 0, n_acc = 0, n_issued = 0, n_done = 0, first_v = -1;
  bit prev_stall = 0;
  logic [DW-1:0] prev_data;
  logic [9:0] prev_index;

  always @(negedge clk) begin
    if (frame_id != seen_id) begin
      seen_id = frame_id; n_acc = 0; n_issued = 0; n_done = 0; first_v = -1; prev_stall = 0;
    end
    if (mon_en) begin
      if (prev_stall) begin
        chk("stall_valid", 32'(bus.px_valid), 1);
        chk("stall_data", bus.px_data, prev_data);
        chk("stall_index", 32'(bus.px_index), 32'(prev_index));
      end
      prev_stall = bus.px_valid && !bus.px_ready;
      prev_data  = bus.px_data;
      prev_index = bus.px_index;
      if (bus.px_valid && first_v < 0) first_v = cyc;
      if (bus.px_valid && bus.px_ready) begin
        if (n_acc < NP) begin
          chk("beat_index", 32'(bus.px_index), 32'(n_acc));
          chk("beat_data", bus.px_data, mem[n_acc]);
          chk("beat_last", 32'(bus.px_last), 32'(n_acc == NP - 1));
        end else chk("extra_beat", 32'(n_acc), NP - 1);
        n_acc++;
      end
      if (bus.rd_en) begin
        chk("rd_addr", 32'(bus.rd_addr), 32'(n_issued));
        n_issued++;
        chk("outstanding_le2", 32'(n_issued - n_acc <= 2), 1);
      end
      if (done) begin
        n_done++;
        chk("done_beats", 32'(n_acc), NP);
        chk("set_count", 32'(set_count), 32'(exp_nz));
        chk("done_busy", 32'(busy), 0);
        if (lat_mode == 1) chk("done_latency", 32'(cyc - start_cyc), 787);
        if (lat_mode == 2) chk("release_latency", 32'(cyc - rel_cyc), 784);
      end
    end
  end

  function automatic logic ready_for(input int mode, input int k);
    case (mode)
      0: return 1'b1;
      1: return (k % 4 == 0) || (k % 4 == 3);
      2: return $urandom_range(0, 3) != 0;
      default: return k >= 100;
    endcase
  endfunction

  task automatic check_reset_vals(input string pfx);
    chk({pfx, "_rd_en"}, 32'(bus.rd_en), 0);
    chk({pfx, "_rd_addr"}, 32'(bus.rd_addr), 0);
    chk({pfx, "_px_valid"}, 32'(bus.px_valid), 0);
    chk({pfx, "_px_data"}, bus.px_data, 0);
    chk({pfx, "_px_index"}, 32'(bus.px_index), 0);
    chk({pfx, "_px_last"}, 32'(bus.px_last), 0);
    chk({pfx, "_busy"}, 32'(busy), 0);
    chk({pfx, "_done"}, 32'(done), 0);
    chk({pfx, "_set_count"}, 32'(set_count), 0);
  endtask

  // mode: 0 ready=1, 1 pattern 1001, 2 random, 3 held low 100 cycles then high
  task automatic run_frame(input int mode, input bit mid_start, input bit start_on_done,
                           input int abort_at);
    int k = 0;
    bit pulsed = 0;
    exp_nz = 0;
    for (int i = 0; i < NP; i++) if (mem[i] != 0) exp_nz++;
    lat_mode = (mode == 0) ? 1 : (mode == 3) ? 2 : 0;
    frame_id++;
    mon_en = 1;
    @(posedge clk); #1;
    start = 1'b1; start_cyc = cyc; bus.px_ready = ready_for(mode, 0);
    while (k < 6000) begin
      @(posedge clk); #1; k++;
      start = 1'b0;
      if (n_done > 0) break;
      if (mid_start && !pulsed && n_acc >= 300) begin start = 1'b1; pulsed = 1; end
      if (start_on_done && cyc - start_cyc == 787) start = 1'b1;
      if (mode == 3 && k == 100) begin
        chk("stall_reads", 32'(n_issued), 2);
        chk("stall_rd_en", 32'(bus.rd_en), 0);
        chk("stall_head_index", 32'(bus.px_index), 0);
        chk("stall_head_valid", 32'(bus.px_valid), 1);
        rel_cyc = cyc;
      end
      bus.px_ready = ready_for(mode, k);
      if (abort_at >= 0 && n_acc >= abort_at) begin
        mon_en = 0;
        #2 resetn = 1'b0;
        #1 check_reset_vals("async_reset");
        repeat (3) @(posedge clk);
        #1 chk("reset_no_done", 32'(done), 0);
        resetn = 1'b1;
        return;
      end
    end
    if (k >= 6000) chk("frame_timeout", 0, 1);
    repeat (4) @(posedge clk);
    #1;
    chk("single_done", 32'(n_done), 1);
    chk("idle_busy", 32'(busy), 0);
    if (mode == 0) chk("first_valid_latency", 32'(first_v - start_cyc), 3);
  endtask

  initial begin
    bus.px_ready = 1'b0;
    for (int i = 0; i < NP; i++) mem[i] = '0;
    repeat (3) @(posedge clk);
    #1 check_reset_vals("reset");
    resetn = 1'b1;
    repeat (2) @(posedge clk);

    // blank frame, full throughput, start re-pulsed on the done cycle
    run_frame(0, 0, 1, -1);

    // sparse drawing with fixed corner pixels
    for (int i = 0; i < NP; i++) mem[i] = ($urandom_range(0, 3) == 0) ? $urandom : '0;
    mem[0] = 32'd1; mem[27] = 32'd1; mem[783] = -32'sd5;
    run_frame(0, 0, 0, -1);

    run_frame(1, 0, 0, -1);
    run_frame(3, 0, 0, -1);

    for (int i = 0; i < NP; i++) mem[i] = ($urandom_range(0, 1) == 0) ? $urandom : '0;
    run_frame(2, 1, 0, -1);

    run_frame(2, 0, 0, 400);
    repeat (2) @(posedge clk);
    for (int i = 0; i < NP; i++) mem[i] = ($urandom_range(0, 4) == 0) ? $urandom : '0;
    run_frame(2, 0, 0, -1);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
